// File: rtl/controller_fifo_unstack_pkg.sv
// Shared types and constants for the wide-in, narrow-out unstack FIFO.
// Also holds the clamp that turns load_len into an effective word count.
package controller_pkg;

  localparam int CTRL_DBITS  = 64;
  localparam int CTRL_WR_PKT = 8;
  localparam int CTRL_CNT_W  = $clog2(CTRL_WR_PKT) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Zero, or any count larger than the block, means "the whole block".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned pkt);
    return ((len == 0) || (len > pkt)) ? pkt : len;
  endfunction

endpackage

// File: rtl/controller_fifo_unstack_if.sv
// Load-side and stream-side signals of controller_fifo_unstack.
// Stream handshake: a word moves on every rising clk edge where dout_valid && dout_ready;
// dout_valid never depends on dout_ready, and dout/dout_last hold stable while not accepted.
interface controller_fifo_unstack_if
  import controller_pkg::*;
#(
  parameter int dbits  = CTRL_DBITS,
  parameter int wr_pkt = CTRL_WR_PKT,
  parameter int cbits  = $clog2(wr_pkt) + 1
);
  logic                    load;
  logic [cbits-1:0]        load_len;
  logic [dbits*wr_pkt-1:0] din;
  logic                    load_ready;
  logic [dbits-1:0]        dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic                    dout_last;
  logic                    busy;
  state_e                  dbg_state;

  modport master (
    output load, load_len, din, dout_ready,
    input  load_ready, dout, dout_valid, dout_last, busy, dbg_state
  );

  modport slave (
    input  load, load_len, din, dout_ready,
    output load_ready, dout, dout_valid, dout_last, busy, dbg_state
  );
endinterface

// File: rtl/controller_fifo_unstack_buf.sv
// One held block plus its remaining word count; the block shifts down one word per
// shift so the word to emit always sits in the low dbits, with zeros shifted in on top.
module controller_unstack_buf #(
  parameter int W  = 64,
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load_i,
  input  logic           shift_i,
  input  logic           clear_i,
  input  logic [W*N-1:0] data_i,
  input  logic [CW-1:0]  len_i,
  output logic [W-1:0]   word_o,
  output logic [CW-1:0]  rem_o
);

  logic [W*N-1:0] data_q, data_d;
  logic [CW-1:0]  rem_q, rem_d;

  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    if (clear_i) begin
      data_d = '0;
      rem_d  = '0;
    end else if (load_i) begin
      data_d = data_i;
      rem_d  = len_i;
    end else if (shift_i) begin
      data_d = data_q >> W;
      rem_d  = rem_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      rem_q  <= '0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
    end
  end

  assign word_o = data_q[W-1:0];
  assign rem_o  = rem_q;

endmodule

// File: rtl/controller_fifo_unstack.sv
// Wide-in, narrow-out gearbox: captures a wr_pkt-word block, streams it LSW first.
// CONTROLLER_UNSTACK_DBUF_EN adds a second (shadow) block so loads overlap draining.
module controller_fifo_unstack
  import controller_pkg::*;
#(
  parameter int dbits  = CTRL_DBITS,
  parameter int wr_pkt = CTRL_WR_PKT
) (
  input logic                      clk,
  input logic                      reset_n,
  controller_fifo_unstack_if.slave bus
);

  localparam int cbits = $clog2(wr_pkt) + 1;

  state_e           state_q, state_d;
  logic [cbits-1:0] len_eff;
  logic [dbits-1:0] act_word;
  logic [cbits-1:0] act_rem;
  logic             accept, beat, last_beat;

  assign len_eff   = cbits'(eff_len(32'(bus.load_len), wr_pkt));
  assign accept    = bus.load && bus.load_ready;
  assign beat      = (state_q == DRAIN) && bus.dout_ready;
  assign last_beat = beat && (act_rem == cbits'(1));

`ifdef CONTROLLER_UNSTACK_DBUF_EN
  // Ping-pong pair: sel_q names the draining block, the other one is the shadow.
  logic             sel_q, sel_d, sh_full;
  logic [1:0]       ld, sh, clr;
  logic [dbits-1:0] word [2];
  logic [cbits-1:0] rem  [2];

  for (genvar g = 0; g < 2; g++) begin : g_buf
    controller_unstack_buf #(.W(dbits), .N(wr_pkt), .CW(cbits)) u_buf (
      .clk(clk), .reset_n(reset_n), .load_i(ld[g]), .shift_i(sh[g]), .clear_i(clr[g]),
      .data_i(bus.din), .len_i(len_eff), .word_o(word[g]), .rem_o(rem[g])
    );
  end

  assign act_word       = word[sel_q];
  assign act_rem        = rem[sel_q];
  assign sh_full        = (rem[~sel_q] != '0);
  assign bus.load_ready = !sh_full;
  assign bus.busy       = (state_q == DRAIN) || sh_full;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ld      = '0;
    sh      = '0;
    clr     = '0;
    case (state_q)
      IDLE: if (accept) begin
        ld[sel_q] = 1'b1;
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (accept) ld[~sel_q] = 1'b1;
        // A block loaded on the last beat lands in the shadow and is swapped in at once.
        if (last_beat) begin
          clr[sel_q] = 1'b1;
          if (sh_full || accept) sel_d = ~sel_q;
          else state_d = IDLE;
        end else if (beat) begin
          sh[sel_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sel_q <= 1'b0;
    else          sel_q <= sel_d;
  end
`else
  logic ld, sh, clr;

  controller_unstack_buf #(.W(dbits), .N(wr_pkt), .CW(cbits)) u_buf (
    .clk(clk), .reset_n(reset_n), .load_i(ld), .shift_i(sh), .clear_i(clr),
    .data_i(bus.din), .len_i(len_eff), .word_o(act_word), .rem_o(act_rem)
  );

  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    sh      = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        ld      = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: if (last_beat) begin
        clr     = 1'b1;
        state_d = IDLE;
      end else if (beat) begin
        sh = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign bus.dout_valid = (state_q == DRAIN);
  assign bus.dout       = bus.dout_valid ? act_word : '0;
  assign bus.dout_last  = bus.dout_valid && (act_rem == cbits'(1));
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_controller_fifo_unstack.sv
// Randomized bench for controller_fifo_unstack against a block/word queue model.
module tb_controller_fifo_unstack;
  import controller_pkg::*;

`ifdef CONTROLLER_UNSTACK_DBUF_EN
  localparam int NBLK = 2;
`else
  localparam int NBLK = 1;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  // Expected stream: {last, word}; outstanding = blocks accepted but not fully emitted.
  logic [64:0] exp_q[$];
  int          outstanding;

  controller_fifo_unstack_if bus ();

  controller_fifo_unstack dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic make_block(input logic [23:0] tag, output logic [511:0] blk);
    for (int j = 0; j < 8; j++) blk[64*j +: 64] = {$urandom(), tag, 8'(j)};
  endtask

  // One clock: compare outputs with the model, drive inputs, advance the model.
  task automatic cycle(input logic ld, input logic [3:0] len, input logic [511:0] blk,
                       input logic rdy, output logic beat_o, output logic last_o);
    logic [64:0] head;
    logic        exp_valid, exp_lr, exp_busy, exp_last, acc;
    logic [63:0] exp_dout;
    int          eff;
    exp_valid = (outstanding > 0);
    exp_lr    = (outstanding < NBLK);
    exp_busy  = (outstanding > 0);
    head      = (exp_q.size() > 0) ? exp_q[0] : 65'd0;
    exp_dout  = exp_valid ? head[63:0] : 64'd0;
    exp_last  = exp_valid ? head[64] : 1'b0;
    checks += 5;
    if (bus.dout_valid !== exp_valid) begin
      errors++; $display("FAIL dout_valid: got %b expected %b t=%0t", bus.dout_valid, exp_valid, $time);
    end
    if (bus.load_ready !== exp_lr) begin
      errors++; $display("FAIL load_ready: got %b expected %b t=%0t", bus.load_ready, exp_lr, $time);
    end
    if (bus.busy !== exp_busy) begin
      errors++; $display("FAIL busy: got %b expected %b t=%0t", bus.busy, exp_busy, $time);
    end
    if (bus.dout !== exp_dout) begin
      errors++; $display("FAIL dout: got %h expected %h t=%0t", bus.dout, exp_dout, $time);
    end
    if (bus.dout_last !== exp_last) begin
      errors++; $display("FAIL dout_last: got %b expected %b t=%0t", bus.dout_last, exp_last, $time);
    end
    beat_o = (bus.dout_valid === 1'b1) && rdy;
    last_o = beat_o && (bus.dout_last === 1'b1);
    acc    = ld && exp_lr;
    bus.load       = ld;
    bus.load_len   = len;
    bus.din        = blk;
    bus.dout_ready = rdy;
    @(posedge clk);
    if (exp_valid && rdy) begin
      void'(exp_q.pop_front());
      if (exp_last) outstanding--;
    end
    if (acc) begin
      eff = (len == 0 || len > 8) ? 8 : int'(len);
      for (int j = 0; j < eff; j++) exp_q.push_back({(j == eff - 1), blk[64*j +: 64]});
      outstanding++;
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0, 2: random ready.
  task automatic drain(input int mode, input int budget, output int cyc, output int beats,
                       output int lasts);
    logic b, l, r;
    logic [511:0] z;
    z = '0; cyc = 0; beats = 0; lasts = 0;
    while (outstanding > 0 && cyc < budget) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'(($urandom_range(0, 3) != 0));
      cycle(1'b0, 4'd0, z, r, b, l);
      cyc++;
      if (b) beats++;
      if (l) lasts++;
    end
    checks++;
    if (outstanding > 0) begin
      errors++; $display("FAIL drain_timeout: %0d blocks left after %0d cycles", outstanding, cyc);
    end
  endtask

  task automatic test_reset();
    #7;
    checks += 5;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.dout_valid); end
    if (bus.dout !== 64'd0) begin errors++; $display("FAIL rst_dout: got %h expected 0", bus.dout); end
    if (bus.dout_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", bus.dout_last); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready: got %b expected 1", bus.load_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_full_block();
    logic [511:0] blk;
    logic b, l;
    int cyc, beats, lasts;
    make_block(24'h0f0f01, blk);
    cycle(1'b1, 4'd0, blk, 1'b1, b, l);
    drain(0, 40, cyc, beats, lasts);
    checks += 3;
    if (beats != 8) begin errors++; $display("FAIL full_beats: got %0d expected 8", beats); end
    if (lasts != 1) begin errors++; $display("FAIL full_lasts: got %0d expected 1", lasts); end
    if (cyc != 8) begin errors++; $display("FAIL full_cycles: got %0d expected 8", cyc); end
  endtask

  task automatic test_backpressure();
    logic [511:0] blk;
    logic b, l;
    int cyc, beats, lasts;
    make_block(24'h0b0b02, blk);
    cycle(1'b1, 4'd0, blk, 1'b0, b, l);
    drain(1, 60, cyc, beats, lasts);
    checks += 2;
    if (beats != 8) begin errors++; $display("FAIL bp_beats: got %0d expected 8", beats); end
    if (lasts != 1) begin errors++; $display("FAIL bp_lasts: got %0d expected 1", lasts); end
  endtask

  task automatic test_length();
    logic [511:0] blk;
    logic b, l;
    int cyc, beats, lasts;
    int lens[3] = '{4, 1, 12};
    int want[3] = '{4, 1, 8};
    for (int i = 0; i < 3; i++) begin
      make_block(24'h1e1e00 + 24'(i), blk);
      cycle(1'b1, 4'(lens[i]), blk, 1'b1, b, l);
      drain(2, 60, cyc, beats, lasts);
      checks += 2;
      if (beats != want[i]) begin errors++; $display("FAIL len%0d_beats: got %0d expected %0d", lens[i], beats, want[i]); end
      if (lasts != 1) begin errors++; $display("FAIL len%0d_lasts: got %0d expected 1", lens[i], lasts); end
      cycle(1'b0, 4'd0, blk, 1'b1, b, l);
    end
  endtask

  task automatic test_load_during_drain();
    logic [511:0] a, c;
    logic b, l;
    int cyc, beats, lasts, pre;
    make_block(24'h0a0a03, a);
    make_block(24'h0c0c04, c);
    pre = 0;
    cycle(1'b1, 4'd0, a, 1'b1, b, l);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 4'd0, a, 1'b1, b, l);
      if (b) pre++;
    end
    cycle(1'b1, 4'd0, c, 1'b1, b, l);
    if (b) pre++;
    drain(0, 40, cyc, beats, lasts);
    checks += 2;
    if (pre + beats != 8 * NBLK) begin
      errors++; $display("FAIL ldd_beats: got %0d expected %0d", pre + beats, 8 * NBLK);
    end
    if (lasts != NBLK) begin errors++; $display("FAIL ldd_lasts: got %0d expected %0d", lasts, NBLK); end
  endtask

  task automatic test_reset_mid_drain();
    logic [511:0] blk;
    logic b, l;
    int cyc, beats, lasts;
    make_block(24'h0d0d05, blk);
    cycle(1'b1, 4'd0, blk, 1'b1, b, l);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'd0, blk, 1'b1, b, l);
    #2 reset_n = 1'b0;
    #1;
    checks += 5;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.dout_valid); end
    if (bus.dout !== 64'd0) begin errors++; $display("FAIL mid_rst_dout: got %h expected 0", bus.dout); end
    if (bus.dout_last !== 1'b0) begin errors++; $display("FAIL mid_rst_last: got %b expected 0", bus.dout_last); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
    if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_load_ready: got %b expected 1", bus.load_ready); end
    exp_q.delete();
    outstanding = 0;
    @(negedge clk);
    reset_n = 1'b1;
    make_block(24'h0e0e06, blk);
    cycle(1'b1, 4'd5, blk, 1'b1, b, l);
    drain(0, 40, cyc, beats, lasts);
    checks++;
    if (beats != 5) begin errors++; $display("FAIL post_rst_beats: got %0d expected 5", beats); end
  endtask

  task automatic test_random();
    logic [511:0] blk;
    logic b, l, ld, r;
    int cyc, beats, lasts;
    for (int k = 0; k < 400; k++) begin
      make_block(24'(k), blk);
      ld = ($urandom_range(0, 2) == 0);
      r  = 1'($urandom_range(0, 1));
      cycle(ld, 4'($urandom_range(0, 15)), blk, r, b, l);
    end
    drain(2, 200, cyc, beats, lasts);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    outstanding = 0;
    reset_n = 1'b0;
    bus.load = 1'b0;
    bus.load_len = '0;
    bus.din = '0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_full_block();
    test_backpressure();
    test_length();
    test_load_during_drain();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
